somador_serial_4b: RTL and testbench
====================================

// Module: somador_serial_4b
// PURPOSE
//  Bit-serial adder: the adding counterpart of the 4-bit ripple subtractor.
//  One full-adder cell plus a carry flop replace the WIDTH-cell ripple chain.
//  Operands are loaded on a start pulse and added LSB-first, one bit per clock.
//  The sum is published with a one-cycle done pulse.
//  Used where area matters more than latency; it shares the a/b/cin/s/cout conventions.
// PARAMETERS
//  WIDTH   4   operand/sum width in bits (>=2)
// PORTS
//  clk    in   1      single clock; all state updates on the rising edge
//  rst    in   1      synchronous, active-high reset
//  start  in   1      request; sampled only when ready (IDLE or DONE)
//  a      in   WIDTH  operand A; captured on an accepted start
//  b      in   WIDTH  operand B; captured on an accepted start
//  cin    in   1      carry-in; captured on an accepted start
//  busy   out  1      high while in ADD
//  done   out  1      one-cycle pulse; s/cout are valid in this cycle
//  s      out  WIDTH  registered sum; holds until the next done
//  cout   out  1      registered carry-out; holds until the next done
// BEHAVIOUR
//  Reset:
//   - rst=1 at any edge forces state=IDLE and busy=done=0, s=0, cout=0.
//   - Shift registers, carry flop and bit counter are cleared.
//   - Reset mid-operation abandons the operation; no done is generated.
//  FSM states: IDLE, ADD, DONE.
//   - IDLE: start=1 -> load a, b, cin into sh_a, sh_b, carry; cnt=0; go to ADD.
//   - ADD, every cycle:
//       sum_bit = sh_a[0]^sh_b[0]^carry
//       carry  <= maj(sh_a[0], sh_b[0], carry)
//       sh_a, sh_b shift right by one
//       sum_bit shifts into sh_s MSB
//       cnt increments
//   - ADD exit: after the cycle with cnt==WIDTH-1, go to DONE.
//     On that edge: s <= final sh_s, cout <= final carry.
//   - DONE: done=1 for this single cycle.
//       start=1 -> load and go straight to ADD (back-to-back operation).
//       start=0 -> go to IDLE.
//  Latency and hold:
//   - Start accepted at edge 0 -> done high in the cycle after edge WIDTH.
//     This is WIDTH+1 cycles from start to done; 5 cycles for WIDTH=4.
//   - s/cout change only on the edge that enters DONE; stable otherwise.
//  Handshake and arithmetic:
//   - start while busy=1 is ignored: no reload, no queuing.
//   - busy=1 exactly in ADD; done and busy are never both high.
//   - Result: {cout,s} = a + b + cin, unsigned, WIDTH+1 bits, no saturation.
//   - Overflow wraps mod 2^WIDTH; the carry appears on cout.
// CONFIGURATION
//  SOMADOR_SERIAL_OVF_EN defined:
//   - Adds output port ovf (1 bit), registered with s/cout.
//   - ovf = carry into MSB XOR carry out of MSB, i.e. two's-complement overflow.
//   - ovf resets to 0 and holds like s.
//  SOMADOR_SERIAL_OVF_EN undefined:
//   - No ovf port and no extra flop; behaviour is otherwise identical.
// TESTING (WIDTH=4)
//  1 a=3, b=5, cin=0, start at edge 0
//     -> busy cycles 1..4; done in cycle 5; s=8, cout=0.
//  2 a=F, b=1, cin=0 -> s=0, cout=1.
//    Then a=F, b=F, cin=1 -> s=F, cout=1.
//  3 start at the edge entering cycle 2 with a=0, b=0 during op a=2, b=2
//     -> ignored; done once with s=4; no second done.
//  4 start held high with new operands in the DONE cycle
//     -> second op begins immediately; next done 5 cycles later.
//     Sweep all 512 a/b/cin combinations against the a+b+cin model.
//  5 rst=1 in cycle 2 of an operation -> next cycle busy=0, done=0, s=0, cout=0.
//     No done follows; a new start then behaves as in case 1.
//  6 (SOMADOR_SERIAL_OVF_EN) a=7, b=1 -> s=8, ovf=1.
//     a=F, b=1 -> s=0, cout=1, ovf=0.

Source files
------------

// File: rtl/somador_serial_4b.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB first, one bit per clock.
// Define SOMADOR_SERIAL_OVF_EN to add the registered two's-complement overflow output ovf.
module somador_serial_4b #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SOMADOR_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-2:0] sh_s;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             load;
    logic             last;
    logic             sum_bit;
    logic             carry_n;
    logic [WIDTH-1:0] s_next;

    assign busy    = (state == ADD);
    assign done    = (state == DONE);
    assign load    = (state != ADD) && start;
    assign last    = (cnt == CW'(WIDTH - 1));
    assign sum_bit = sh_a[0] ^ sh_b[0] ^ carry;
    assign carry_n = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
    // Sum bits enter at the top, so the final shift leaves the whole sum aligned.
    assign s_next  = {sum_bit, sh_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = ADD;
            ADD:     if (last) state_n = DONE;
            DONE:    state_n = start ? ADD : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
`ifdef SOMADOR_SERIAL_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (load) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ADD) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            sh_s  <= s_next[WIDTH-1:1];
            carry <= carry_n;
            cnt   <= cnt + 1'b1;
            if (last) begin
                s    <= s_next;
                cout <= carry_n;
`ifdef SOMADOR_SERIAL_OVF_EN
                // On the last bit, carry is the carry into the MSB.
                ovf  <= carry ^ carry_n;
`endif
            end
        end
    end

endmodule

// File: tb/tb_somador_serial_4b.sv
// Self-checking bench for somador_serial_4b: arithmetic/latency model plus directed vectors.
// Build with SOMADOR_SERIAL_OVF_EN defined to also check ovf.
module tb_somador_serial_4b;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] s;
    logic         cout;
`ifdef SOMADOR_SERIAL_OVF_EN
    logic         ovf;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    somador_serial_4b #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
`ifdef SOMADOR_SERIAL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Model: an accepted start schedules the result WIDTH edges later.
    int           left    = 0;
    int           pend    = 0;
    bit           pend_ov = 1'b0;
    bit           m_done  = 1'b0;
    int           m_res   = 0;
    bit           m_ovf   = 1'b0;

    function automatic bit signed_ovf(input int x, input int y, input int c);
        int sx, sy, sv;
        sx = (x >= 2 ** (W - 1)) ? x - 2 ** W : x;
        sy = (y >= 2 ** (W - 1)) ? y - 2 ** W : y;
        sv = sx + sy + c;
        return (sv > 2 ** (W - 1) - 1) || (sv < -(2 ** (W - 1)));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            left   = 0;
            m_done = 1'b0;
            m_res  = 0;
            m_ovf  = 1'b0;
        end else if (left == 0 && start) begin
            left    = W;
            pend    = int'(a) + int'(b) + int'(cin);
            pend_ov = signed_ovf(int'(a), int'(b), int'(cin));
            m_done  = 1'b0;
        end else if (left > 0) begin
            left = left - 1;
            m_done = (left == 0);
            if (left == 0) begin
                m_res = pend;
                m_ovf = pend_ov;
            end
        end else begin
            m_done = 1'b0;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            bit ok;
            ok = (busy === (left > 0)) && (done === m_done)
              && ({cout, s} === (W + 1)'(m_res));
`ifdef SOMADOR_SERIAL_OVF_EN
            ok = ok && (ovf === m_ovf);
`endif
            n_checks++;
            if (ok) n_pass++;
            else $display("FAIL model t=%0t: busy=%b done=%b cout=%b s=%h, expected busy=%b done=%b res=%h",
                          $time, busy, done, cout, s, left > 0, m_done, m_res);
        end
    end

    // Drive one start, return at the negedge of the done cycle with the cycle count.
    task automatic run_op(input int ia, input int ib, input int ic, output int lat);
        start = 1'b1;
        a = W'(ia);
        b = W'(ib);
        cin = ic[0];
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        int lat, nd;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_sum", int'({cout, s}), 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // 1: 3+5
        run_op(3, 5, 0, lat);
        check("t1_latency", lat, 5);
        check("t1_sum", int'(s), 8);
        check("t1_cout", int'(cout), 0);

        // 2: wrap and full carry
        run_op(15, 1, 0, lat);
        check("t2a_sum", int'({cout, s}), 16);
        run_op(15, 15, 1, lat);
        check("t2b_sum", int'(s), 15);
        check("t2b_cout", int'(cout), 1);
        @(negedge clk);

        // 3: start during ADD is ignored
        start = 1'b1;
        a = 4'd2;
        b = 4'd2;
        cin = 1'b0;
        @(negedge clk);
        a = 4'd0;
        b = 4'd0;
        @(negedge clk);
        start = 1'b0;
        count_dones(12, nd);
        check("t3_dones", nd, 1);
        check("t3_sum", int'({cout, s}), 4);

        // 4: back-to-back sweep over all operands
        for (int i = 0; i < 512; i++) begin
            run_op(i[3:0], i[7:4], int'(i[8]), lat);
            check("t4_latency", lat, 5);
            check("t4_sum", int'({cout, s}), int'(i[3:0]) + int'(i[7:4]) + int'(i[8]));
        end
        @(negedge clk);
        @(negedge clk);

        // 5: reset mid-operation
        start = 1'b1;
        a = 4'd3;
        b = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", int'(busy), 0);
        check("t5_done", int'(done), 0);
        check("t5_sum", int'({cout, s}), 0);
        count_dones(8, nd);
        check("t5_no_done", nd, 0);
        run_op(3, 5, 0, lat);
        check("t5_latency", lat, 5);
        check("t5_resum", int'({cout, s}), 8);

`ifdef SOMADOR_SERIAL_OVF_EN
        // 6: signed overflow
        run_op(7, 1, 0, lat);
        check("t6a_sum", int'(s), 8);
        check("t6a_ovf", int'(ovf), 1);
        run_op(15, 1, 0, lat);
        check("t6b_sum", int'({cout, s}), 16);
        check("t6b_ovf", int'(ovf), 0);
`endif
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
